// File: rtl/debounce_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debounce_scan_pkg
// Purpose  : Shared types for the debounce scan controller: scan FSM state
//            encoding, the queued level-change event record, and a constant
//            ceil(log2) helper used to size channel indices and pointers.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package debounce_scan_pkg;

    // Scan scheduler states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // The channel field is sized for the largest supported channel count so
    // the event record has one fixed layout; users slice off the low bits.
    localparam int EVT_CHAN_W = 8;

    typedef struct packed {
        logic [EVT_CHAN_W-1:0] chan;
        logic                  level;
    } evt_t;

    localparam int EVT_W = $bits(evt_t);

    // ceil(log2(n)), never below 1 so single-bit indices remain legal
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : debounce_scan_ctrl_if
// Purpose  : Valid/ready event port between the debounce scan controller
//            (master, produces events) and the register interface (slave,
//            consumes events).
// Signals  : evt_valid  master->slave  head event present
//            evt_ready  slave->master  consumer accepts head this cycle
//            evt_chan   master->slave  channel of head event (CHAN_W bits)
//            evt_level  master->slave  new debounced level of head event
// Revision : 1.0  initial release
// ============================================================================
interface debounce_scan_ctrl_if #(
    parameter int CHAN_W = 2
);
    logic              evt_valid;
    logic              evt_ready;
    logic [CHAN_W-1:0] evt_chan;
    logic              evt_level;

    modport master (
        output evt_valid,
        output evt_chan,
        output evt_level,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_chan,
        input  evt_level,
        output evt_ready
    );
endinterface
`default_nettype wire

// File: rtl/debounce_scan_fifo.sv
`default_nettype none
// ============================================================================
// Module   : debounce_scan_fifo
// Purpose  : Synchronous FIFO of level-change events. Head is presented
//            combinationally from storage. A push while full is accepted only
//            when a pop happens in the same cycle; otherwise it is dropped.
// Ports    : clk        in   system clock
//            rst_n      in   synchronous reset, active low
//            push       in   write push_data
//            push_data  in   event to enqueue
//            pop        in   remove head (ignored when empty)
//            head       out  event at head of queue
//            full       out  all DEPTH entries occupied
//            empty      out  no entries
// Revision : 1.0  initial release
// ============================================================================
module debounce_scan_fifo
    import debounce_scan_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  evt_t push_data,
    input  logic pop,
    output evt_t head,
    output logic full,
    output logic empty
);

    localparam int AW = clog2(DEPTH);

    evt_t        r_mem_q [DEPTH];
    evt_t        w_mem_d [DEPTH];
    logic [AW:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [AW:0] r_rd_ptr_q, w_rd_ptr_d;
    logic        w_push_ok;
    logic        w_pop_ok;

    // Pointers carry one wrap bit: equal -> empty, differ only in wrap -> full
    assign empty = (r_wr_ptr_q == r_rd_ptr_q);
    assign full  = (r_wr_ptr_q[AW] != r_rd_ptr_q[AW]) &&
                   (r_wr_ptr_q[AW-1:0] == r_rd_ptr_q[AW-1:0]);
    assign head  = r_mem_q[r_rd_ptr_q[AW-1:0]];

    // A pop frees the head slot in the same edge, so push+pop while full is safe
    assign w_push_ok = push && (!full || pop);
    assign w_pop_ok  = pop && !empty;

    always_comb begin
        w_mem_d    = r_mem_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        if (w_push_ok) begin
            w_mem_d[r_wr_ptr_q[AW-1:0]] = push_data;
            w_wr_ptr_d                  = r_wr_ptr_q + 1'b1;
        end
        if (w_pop_ok) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_mem_q    <= w_mem_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/debounce_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : debounce_scan_ctrl
// Purpose  : Debounce scheduler. A shared prescaler produces a sample tick;
//            each tick starts a round-robin pass that shifts one raw input
//            per clock into that channel's history. A channel's debounced
//            level flips once its history is uniformly the opposite value,
//            and every flip is queued as an event on the valid/ready port.
// Ports    : clk          in   system clock
//            rst_n        in   synchronous reset, active low
//            enable       in   prescaler runs / ticks accepted
//            div_val      in   tick period = div_val+1 cycles (read on reload)
//            raw_in       in   synchronised raw inputs, bit i = channel i
//            level_out    out  debounced levels
//            busy         out  high while a scan pass is running
//            evt          if   event port (master modport)
//            overrun      out  sticky dropped-event flag  (optional)
//            overrun_clr  in   clears overrun; set wins    (optional)
// Config   : DEBOUNCE_SCAN_OVERRUN_EN adds overrun/overrun_clr ports.
// Revision : 1.0  initial release
// ============================================================================
module debounce_scan_ctrl
    import debounce_scan_pkg::*;
#(
    parameter int NCH        = 3,
    parameter int HIST_LEN   = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [DIV_W-1:0]     div_val,
    input  logic [NCH-1:0]       raw_in,
    output logic [NCH-1:0]       level_out,
    output logic                 busy,
    debounce_scan_ctrl_if.master evt
`ifdef DEBOUNCE_SCAN_OVERRUN_EN
    ,
    output logic                 overrun,
    input  logic                 overrun_clr
`endif
);

    localparam int                CHAN_W    = clog2(NCH);
    localparam logic [CHAN_W-1:0] C_LAST_CH = CHAN_W'(NCH - 1);

    state_t              r_state_q, w_state_d;
    logic [CHAN_W-1:0]   r_ch_idx_q, w_ch_idx_d;
    logic                r_pending_q, w_pending_d;
    logic [DIV_W-1:0]    r_cnt_q, w_cnt_d;
    logic [HIST_LEN-1:0] r_hist_q [NCH];
    logic [HIST_LEN-1:0] w_hist_d [NCH];
    logic [NCH-1:0]      r_level_q, w_level_d;

    logic                w_tick;
    logic                w_push;
    evt_t                w_push_evt;
    evt_t                w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic [HIST_LEN-1:0] w_old_hist;
    logic                w_raw_bit;
    logic                w_unused_chan;

    // ------------------------------------------------------------------
    // Prescaler: disabled counter sits at the reload value so the first
    // tick after enabling arrives a full period later.
    // ------------------------------------------------------------------
    assign w_tick = enable && (r_cnt_q == '0);

    always_comb begin
        w_cnt_d = r_cnt_q - 1'b1;
        if (!enable || w_tick) begin
            w_cnt_d = div_val;
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM and per-channel debounce update
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d   = r_state_q;
        w_ch_idx_d  = r_ch_idx_q;
        w_pending_d = r_pending_q;
        w_hist_d    = r_hist_q;
        w_level_d   = r_level_q;
        w_push      = 1'b0;
        w_old_hist  = r_hist_q[r_ch_idx_q];
        w_raw_bit   = raw_in[r_ch_idx_q];
        w_push_evt  = '0;

        case (r_state_q)
            ST_IDLE: begin
                if (w_tick) begin
                    w_state_d  = ST_SCAN;
                    w_ch_idx_d = '0;
                end
            end
            ST_SCAN: begin
                w_hist_d[r_ch_idx_q] = {w_old_hist[HIST_LEN-2:0], w_raw_bit};
                // Decision uses the pre-shift history: HIST_LEN agreeing
                // samples already stored before the level may change.
                if ((&w_old_hist) && !r_level_q[r_ch_idx_q]) begin
                    w_level_d[r_ch_idx_q] = 1'b1;
                    w_push                = 1'b1;
                end else if (!(|w_old_hist) && r_level_q[r_ch_idx_q]) begin
                    w_level_d[r_ch_idx_q] = 1'b0;
                    w_push                = 1'b1;
                end
                w_push_evt.chan  = EVT_CHAN_W'(r_ch_idx_q);
                w_push_evt.level = w_level_d[r_ch_idx_q];

                if (r_ch_idx_q == C_LAST_CH) begin
                    w_ch_idx_d = '0;
                    if (r_pending_q || w_tick) begin
                        // Start the next pass straight away; one owed tick consumed
                        w_pending_d = 1'b0;
                    end else begin
                        w_state_d = ST_IDLE;
                    end
                end else begin
                    w_ch_idx_d = r_ch_idx_q + 1'b1;
                    if (w_tick) begin
                        w_pending_d = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // Disabling drops any owed pass; an in-flight pass still completes
        if (!enable) begin
            w_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q   <= ST_IDLE;
            r_ch_idx_q  <= '0;
            r_pending_q <= 1'b0;
            r_cnt_q     <= div_val;
            r_level_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_hist_q[i] <= '0;
            end
        end else begin
            r_state_q   <= w_state_d;
            r_ch_idx_q  <= w_ch_idx_d;
            r_pending_q <= w_pending_d;
            r_cnt_q     <= w_cnt_d;
            r_level_q   <= w_level_d;
            r_hist_q    <= w_hist_d;
        end
    end

    // ------------------------------------------------------------------
    // Event queue
    // ------------------------------------------------------------------
    assign w_pop = !w_empty && evt.evt_ready;

    debounce_scan_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_evt),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign evt.evt_valid = !w_empty;
    assign evt.evt_chan  = w_head.chan[CHAN_W-1:0];
    assign evt.evt_level = w_head.level;
    // Upper channel bits of the fixed-width event record are always zero
    assign w_unused_chan = ^w_head.chan;

    assign level_out = r_level_q;
    assign busy      = (r_state_q == ST_SCAN);

`ifdef DEBOUNCE_SCAN_OVERRUN_EN
    logic r_overrun_q, w_overrun_d;
    logic w_drop;

    // Same condition under which the FIFO refuses a push
    assign w_drop = w_push && w_full && !w_pop;

    always_comb begin
        w_overrun_d = r_overrun_q;
        if (w_drop) begin
            w_overrun_d = 1'b1;
        end else if (overrun_clr) begin
            w_overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overrun_q <= 1'b0;
        end else begin
            r_overrun_q <= w_overrun_d;
        end
    end

    assign overrun = r_overrun_q;
`else
    logic w_unused_full;
    assign w_unused_full = w_full;
`endif

endmodule
`default_nettype wire
